// File: rtl/capture_buffer_ctrl.sv
// Trigger-capture buffer: circular pre-trigger history, post-trigger fill, then in-order
// playback of the full DEPTH-word window through a request/valid port with 1-cycle latency.
module capture_buffer_ctrl #(
  parameter int NB_DATA = 14,
  parameter int NB_ADDR = 11
) (
  input  logic               clock,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_arm,
  input  logic               i_trigger,
  input  logic               i_mode,
  input  logic [NB_ADDR-1:0] i_pretrig,
  input  logic               i_rd_req,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_rd_last,
  output logic               o_full,
  output logic               o_overrun,
  output logic [1:0]         o_state
);

  localparam int DEPTH = 2**NB_ADDR;

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, POST = 2'd2, READ = 2'd3} state_t;

  state_t             state_q, state_d;
  logic               arm_prev_q;
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d, pre_cnt_q, pre_cnt_d, pretrig_q, pretrig_d;
  logic [NB_ADDR-1:0] start_q, start_d, rd_ptr_q, rd_ptr_d, rd_cnt_q, rd_cnt_d;
  logic [NB_ADDR:0]   post_cnt_q, post_cnt_d, post_target, post_inc;
  logic               overrun_q, overrun_d, rd_valid_q, rd_last_q;
  logic [NB_DATA-1:0] rd_data_q;
  logic [NB_DATA-1:0] mem [DEPTH];

  logic arm_pulse, wr_en, trig_ok, last_wr, rd_fire, rd_final, reinit;

  assign arm_pulse   = i_arm && !arm_prev_q;
  assign wr_en       = i_valid && (state_q == PRE || state_q == POST);
  assign trig_ok     = (state_q == PRE) && i_trigger && (pre_cnt_q == pretrig_q);
  assign post_target = {1'b1, {NB_ADDR{1'b0}}} - {1'b0, pretrig_q};
  assign post_inc    = post_cnt_q + (NB_ADDR+1)'(1);
  assign rd_fire     = (state_q == READ) && i_rd_req;
  assign rd_final    = rd_fire && (rd_cnt_q == '1);
  assign reinit      = ((state_q == IDLE) && arm_pulse) || (rd_final && i_mode);

  // On a qualified trigger the same-cycle sample may already be the last one (pretrig = DEPTH-1)
  always_comb begin
    last_wr = 1'b0;
    if (state_q == PRE)
      last_wr = trig_ok && i_valid && (post_target == (NB_ADDR+1)'(1));
    else if (state_q == POST)
      last_wr = i_valid && (post_inc == post_target);
  end

  always_ff @(posedge clock) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm_pulse) state_d = PRE;
      PRE:     if (trig_ok)   state_d = last_wr ? READ : POST;
      POST:    if (last_wr)   state_d = READ;
      READ:    if (rd_final)  state_d = i_mode ? PRE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_state    = state_q;
    o_full     = (state_q == READ);
    o_overrun  = overrun_q;
    o_rd_valid = rd_valid_q;
    o_rd_last  = rd_last_q;
    o_rd_data  = rd_data_q;
  end

  // pretrig needs no clamp: an NB_ADDR-wide value can never exceed DEPTH-1
  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + NB_ADDR'(1) : wr_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    pretrig_d  = pretrig_q;
    start_d    = start_q;
    post_cnt_d = post_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    overrun_d  = overrun_q;
    if (state_q == PRE && wr_en && pre_cnt_q != pretrig_q)
      pre_cnt_d = pre_cnt_q + NB_ADDR'(1);
    if (trig_ok) begin
      start_d    = wr_ptr_q - pretrig_q;
      post_cnt_d = {{NB_ADDR{1'b0}}, i_valid};
    end else if (state_q == POST && i_valid) begin
      post_cnt_d = post_inc;
    end
    if (state_d == READ && state_q != READ) begin
      rd_ptr_d = start_d;
      rd_cnt_d = '0;
    end else if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + NB_ADDR'(1);
      rd_cnt_d = rd_cnt_q + NB_ADDR'(1);
    end
    if (state_q == READ && i_valid)
      overrun_d = 1'b1;
    if (reinit) begin
      wr_ptr_d  = '0;
      pre_cnt_d = '0;
      pretrig_d = i_pretrig;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (i_rst) begin
      arm_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      pre_cnt_q  <= '0;
      pretrig_q  <= '0;
      start_q    <= '0;
      post_cnt_q <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      arm_prev_q <= i_arm;
      wr_ptr_q   <= wr_ptr_d;
      pre_cnt_q  <= pre_cnt_d;
      pretrig_q  <= pretrig_d;
      start_q    <= start_d;
      post_cnt_q <= post_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= rd_fire;
      rd_last_q  <= rd_final;
      if (rd_fire) rd_data_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= i_data;
  end

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// Bench for capture_buffer_ctrl: vector table, directed capture scenarios and random
// traffic, all checked against a queue-based window model.
module tb_capture_buffer_ctrl;
  localparam int NB_DATA = 14;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 16;

  logic               clock = 1'b0;
  logic               i_rst, i_valid, i_arm, i_trigger, i_mode, i_rd_req;
  logic [NB_DATA-1:0] i_data;
  logic [NB_ADDR-1:0] i_pretrig;
  logic [NB_DATA-1:0] o_rd_data;
  logic               o_rd_valid, o_rd_last, o_full, o_overrun;
  logic [1:0]         o_state;

  always #5 clock = ~clock;

  capture_buffer_ctrl #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clock(clock), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .i_arm(i_arm),
    .i_trigger(i_trigger), .i_mode(i_mode), .i_pretrig(i_pretrig), .i_rd_req(i_rd_req),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last),
    .o_full(o_full), .o_overrun(o_overrun), .o_state(o_state)
  );

  int errors = 0;
  int checks = 0;
  int ramp   = 0;

  // Reference model: sample history and captured window as queues
  int m_state = 0, m_arm_prev = 0, m_pre = 0, m_pretrig = 0, m_need = 0, m_idx = 0, m_overrun = 0;
  int e_valid = 0, e_last = 0, e_data = 0;
  int hist[$];
  int win[$];

  typedef struct {
    bit       rst, arm, trig, valid, rdreq;
    bit [3:0] pre;
    int       st;
    bit       ovr;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reinit();
    hist.delete();
    m_pre     = 0;
    m_pretrig = int'(i_pretrig);
    m_overrun = 0;
    m_state   = 1;
  endfunction

  task automatic model_step();
    bit pulse;
    e_valid = 0;
    e_last  = 0;
    if (i_rst) begin
      m_state = 0; m_arm_prev = 0; m_overrun = 0;
      hist.delete(); win.delete();
      return;
    end
    pulse = i_arm && (m_arm_prev == 0);
    m_arm_prev = int'(i_arm);
    case (m_state)
      0: if (pulse) m_reinit();
      1: begin
        if (i_trigger && m_pre == m_pretrig) begin
          win.delete();
          for (int k = hist.size() - m_pretrig; k < hist.size(); k++) win.push_back(hist[k]);
          m_need = DEPTH - m_pretrig;
          if (i_valid) begin win.push_back(int'(i_data)); m_need--; end
          m_idx   = 0;
          m_state = (m_need == 0) ? 3 : 2;
        end else if (i_valid) begin
          hist.push_back(int'(i_data));
          if (hist.size() > DEPTH) void'(hist.pop_front());
          if (m_pre < m_pretrig) m_pre++;
        end
      end
      2: if (i_valid) begin
        win.push_back(int'(i_data));
        m_need--;
        if (m_need == 0) begin m_state = 3; m_idx = 0; end
      end
      default: begin
        if (i_valid) m_overrun = 1;
        if (i_rd_req) begin
          e_valid = 1;
          e_data  = win[m_idx];
          e_last  = (m_idx == DEPTH-1) ? 1 : 0;
          m_idx++;
          if (m_idx == DEPTH) begin
            if (i_mode) m_reinit();
            else m_state = 0;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    i_data = i_valid ? NB_DATA'(ramp) : NB_DATA'($urandom);
    @(posedge clock);
    model_step();
    if (i_valid) ramp++;
    #1;
    chk("state", int'(o_state), m_state);
    chk("full", int'(o_full), (m_state == 3) ? 1 : 0);
    chk("overrun", int'(o_overrun), m_overrun);
    chk("rd_valid", int'(o_rd_valid), e_valid);
    chk("rd_last", int'(o_rd_last), e_last);
    if (e_valid != 0) chk("rd_data", int'(o_rd_data), e_data);
  endtask

  task automatic do_reset();
    i_rst = 1; i_arm = 0; i_trigger = 0; i_valid = 0; i_rd_req = 0;
    tick();
    i_rst = 0;
  endtask

  task automatic do_arm(input int p, input bit mode);
    i_arm = 0; i_valid = 0; i_trigger = 0; i_rd_req = 0; i_mode = mode;
    i_pretrig = NB_ADDR'(p);
    tick();
    i_arm = 1;
    tick();
    chk("arm_pre", int'(o_state), 1);
    ramp = 0;
  endtask

  task automatic feed(input int last, input int trig_at);
    i_valid = 1;
    while (ramp <= last) begin
      i_trigger = (ramp == trig_at);
      tick();
    end
    i_valid = 0; i_trigger = 0;
  endtask

  task automatic read_all(input int first, input bit valid_in);
    i_valid = valid_in;
    for (int k = 0; k < DEPTH; k++) begin
      i_rd_req = 1;
      tick();
      chk("win_data", int'(o_rd_data), first + k);
      chk("win_last", int'(o_rd_last), (k == DEPTH-1) ? 1 : 0);
    end
    i_rd_req = 0; i_valid = 0;
  endtask

  initial begin
    i_rst = 1; i_arm = 0; i_trigger = 0; i_valid = 0; i_rd_req = 0; i_mode = 0;
    i_pretrig = '0; i_data = '0;

    tbl[0]  = '{1, 1, 1, 1, 1, 4'd3, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 1, 4'd9, 0, 0};
    tbl[2]  = '{1, 1, 0, 1, 1, 4'd5, 0, 0};
    tbl[3]  = '{0, 0, 0, 1, 0, 4'd2, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 1, 4'd2, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 4'd2, 1, 0};
    tbl[6]  = '{0, 1, 1, 1, 0, 4'd7, 1, 0};
    tbl[7]  = '{0, 0, 0, 1, 0, 4'd7, 1, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 4'd7, 1, 0};
    tbl[9]  = '{0, 1, 1, 0, 0, 4'd7, 2, 0};
    tbl[10] = '{0, 1, 0, 1, 0, 4'd7, 2, 0};

    foreach (tbl[i]) begin
      i_rst = tbl[i].rst; i_arm = tbl[i].arm; i_trigger = tbl[i].trig;
      i_valid = tbl[i].valid; i_rd_req = tbl[i].rdreq; i_pretrig = tbl[i].pre;
      tick();
      chk("tbl_state", int'(o_state), tbl[i].st);
      chk("tbl_overrun", int'(o_overrun), int'(tbl[i].ovr));
      chk("tbl_rd_valid", int'(o_rd_valid), 0);
      chk("tbl_rd_last", int'(o_rd_last), 0);
    end

    // pretrig 4, trigger on sample 10
    do_reset();
    do_arm(4, 0);
    feed(21, 10);
    chk("t2_read", int'(o_state), 3);
    read_all(6, 0);
    chk("t2_idle", int'(o_state), 0);
    i_rd_req = 1; tick(); i_rd_req = 0;
    chk("t2_req_idle", int'(o_rd_valid), 0);

    // early trigger discarded, later one qualifies
    do_arm(8, 0);
    feed(19, 3);
    chk("t3_still_pre", int'(o_state), 1);
    feed(27, 20);
    chk("t3_read", int'(o_state), 3);
    read_all(12, 0);

    // pretrig 0 with an arm pulse during POST
    do_arm(0, 0);
    i_valid = 1;
    while (ramp <= 15) begin
      i_trigger = (ramp == 0);
      i_arm = (ramp != 5);
      tick();
      if (ramp == 7) chk("t4_post", int'(o_state), 2);
    end
    i_valid = 0; i_trigger = 0;
    chk("t4_read", int'(o_state), 3);
    read_all(0, 0);

    // auto-rearm with overrun
    do_arm(2, 1);
    feed(15, 2);
    chk("t5_read", int'(o_state), 3);
    i_valid = 1; tick();
    chk("t5_overrun", int'(o_overrun), 1);
    read_all(0, 1);
    chk("t5_rearm", int'(o_state), 1);
    chk("t5_ovr_clr", int'(o_overrun), 0);

    // reset in POST, then maximum pretrig
    i_mode = 0;
    do_reset();
    do_arm(3, 0);
    feed(5, 3);
    chk("t6_post", int'(o_state), 2);
    do_reset();
    chk("t6_reset", int'(o_state), 0);
    do_arm(15, 0);
    feed(30, 30);
    chk("t6_read", int'(o_state), 3);
    read_all(15, 0);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      i_rst     = ($urandom_range(299) == 0);
      if ($urandom_range(19) == 0) i_arm = !i_arm;
      i_trigger = ($urandom_range(5) == 0);
      i_valid   = ($urandom_range(3) != 0);
      i_rd_req  = 1'($urandom);
      if ($urandom_range(99) == 0) i_mode = !i_mode;
      i_pretrig = NB_ADDR'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
